regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks an inclusive address range on one asynchronous
// register-file read port and streams each word over a valid/ready handshake.
// Each word takes a FETCH cycle (address out, data captured) and at least one
// SEND cycle, so the stream runs at most one word every two cycles.
// busy and done are registered: done pulses in the cycle after the internal
// DONE state, and busy covers that pulse, so a new start is taken afterwards.
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum
// beat (out_addr=0, out_last=1) after the last data beat of a non-empty dump.
module regfile_dump_reader #(
    parameter int WORD_LEN   = 32,
    parameter int WORD_COUNT = 32,
    parameter int ADDR_LEN   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] first_addr,
    input  logic [ADDR_LEN-1:0] last_addr,
    output logic [ADDR_LEN-1:0] rf_addr,
    input  logic [WORD_LEN-1:0] rf_data,
    output logic [WORD_LEN-1:0] out_data,
    output logic [ADDR_LEN-1:0] out_addr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_DONE, S_CHK} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;
`endif

    // Highest register in the file; a range reaching past it stops there.
    localparam logic [ADDR_LEN-1:0] LP_MAX_ADDR = ADDR_LEN'(WORD_COUNT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_LEN-1:0] r_cur;
    logic [ADDR_LEN-1:0] r_last;
    logic [WORD_LEN-1:0] r_out_data;
    logic [ADDR_LEN-1:0] r_out_addr;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [WORD_LEN-1:0] r_csum;
`endif

    logic w_accept;
    logic w_nonempty;
    logic w_at_end;
    logic w_xfer;

    assign w_accept   = (r_state == S_IDLE) && start && !r_busy;
    assign w_nonempty = (first_addr <= last_addr);
    // Termination is an equality compare on the current index, so cur never wraps.
    assign w_at_end   = (r_cur == r_last) || (r_cur == LP_MAX_ADDR);
    // out_valid is always high in SEND, so ready alone marks a transfer there.
    assign w_xfer     = (r_state == S_SEND) && out_ready;

    assign rf_addr   = r_cur;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            r_state <= w_next;
        end
    end

    // Next-state selection.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch forms.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_nonempty ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: w_next = S_SEND;
            S_SEND: begin
                if (w_xfer) begin
                    if (r_out_last) begin
                        w_next = S_DONE;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    end else if (w_at_end) begin
                        w_next = S_CHK;
`endif
                    end else begin
                        w_next = S_FETCH;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CHK:   w_next = S_SEND;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Range registers, output beat registers, status flags and checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur       <= '0;
            r_last      <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_busy <= (w_next != S_IDLE) || (r_state == S_DONE);
            r_done <= (r_state == S_DONE);

            if (w_accept) begin
                r_last <= last_addr;
                // An empty range never fetches, so rf_addr keeps its old value.
                if (w_nonempty) begin
                    r_cur <= first_addr;
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                r_csum <= '0;
`endif
            end

            if (r_state == S_FETCH) begin
                r_out_data  <= rf_data;
                r_out_addr  <= r_cur;
                r_out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                r_out_last  <= 1'b0;
`else
                r_out_last  <= w_at_end;
`endif
            end

`ifdef REGFILE_DUMP_CHECKSUM_EN
            if (r_state == S_CHK) begin
                r_out_data  <= r_csum;
                r_out_addr  <= '0;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b1;
            end
`endif

            if (w_xfer) begin
                r_out_valid <= 1'b0;
                if (!r_out_last && !w_at_end) begin
                    r_cur <= r_cur + ADDR_LEN'(1);
                end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                // Only data beats feed the checksum; the checksum beat has out_last set.
                if (!r_out_last) begin
                    r_csum <= r_csum ^ r_out_data;
                end
`endif
            end
        end
    end

endmodule
